// File: rtl/spi_cfg_pkg.sv
// spi_cfg_pkg: shared types and command-field constants for the SPI config-register controller.
package spi_cfg_pkg;
   typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;
   localparam int CMD_RD_BIT = 7;
   localparam int ADDR_W = 7;
   localparam int DATA_W = 8;
   localparam int LOCK_BIT = 0;
   function automatic int lock_idx(input int num_regs);
      return num_regs - 1;
   endfunction
endpackage

// File: rtl/spi_cfg_if.sv
// spi_cfg_if: command, internal-request and register-bank status bundle of spi_cfg_ctrl.
interface spi_cfg_if
   import spi_cfg_pkg::*;
#(
   parameter int NUM_REGS = 16
);
   logic cmd_valid;
   logic [DATA_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_data;
   logic int_req;
   logic [ADDR_W-1:0] int_addr;
   logic [DATA_W-1:0] int_data;
   logic int_gnt;
   logic [NUM_REGS*DATA_W-1:0] reg_out;
   logic wr_strobe;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] rd_data;
   logic rd_valid;
   logic busy;
   logic cmd_overflow;
   logic addr_err;
   modport master (
      output cmd_valid, cmd_addr, cmd_data, int_req, int_addr, int_data,
      input int_gnt, reg_out, wr_strobe, wr_addr, rd_data, rd_valid, busy, cmd_overflow, addr_err
   );
   modport slave (
      input cmd_valid, cmd_addr, cmd_data, int_req, int_addr, int_data,
      output int_gnt, reg_out, wr_strobe, wr_addr, rd_data, rd_valid, busy, cmd_overflow, addr_err
   );
endinterface

// File: rtl/spi_cfg_arb.sv
// spi_cfg_arb: one-deep SPI pending buffer, SPI/internal source select and starvation counter.
module spi_cfg_arb
   import spi_cfg_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic iclk,
   input  logic rstn,
   input  logic idle,
   input  logic cmd_valid,
   input  logic [DATA_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic int_req,
   input  logic [ADDR_W-1:0] int_addr,
   input  logic [DATA_W-1:0] int_data,
   output logic gnt_v,
   output logic gnt_int,
   output logic gnt_rd,
   output logic [ADDR_W-1:0] gnt_addr,
   output logic [DATA_W-1:0] gnt_data,
   output logic cmd_overflow
);
   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
   logic pend_v, spi_v, gnt_spi, live_direct, pend_free;
   logic [DATA_W-1:0] pend_addr, pend_data, sel_addr, sel_data;
   logic [CW-1:0] starve;
   assign spi_v = pend_v | cmd_valid;
   assign sel_addr = pend_v ? pend_addr : cmd_addr;
   assign sel_data = pend_v ? pend_data : cmd_data;
   assign gnt_int = idle & int_req & (!spi_v | (starve == SMAX));
   assign gnt_spi = idle & spi_v & !gnt_int;
   assign gnt_v = gnt_int | gnt_spi;
   assign gnt_rd = gnt_spi & sel_addr[CMD_RD_BIT];
   assign gnt_addr = gnt_int ? int_addr : sel_addr[ADDR_W-1:0];
   assign gnt_data = gnt_int ? int_data : sel_data;
   // a live command is buffered unless it goes straight to the FSM this cycle
   assign live_direct = gnt_spi & !pend_v;
   assign pend_free = !pend_v | gnt_spi;
   always_ff @(posedge iclk or negedge rstn) begin
      if (!rstn) begin
         pend_v <= 1'b0;
         pend_addr <= '0;
         pend_data <= '0;
         starve <= '0;
         cmd_overflow <= 1'b0;
      end else begin
         if (cmd_valid && !live_direct) begin
            if (pend_free) begin
               pend_v <= 1'b1;
               pend_addr <= cmd_addr;
               pend_data <= cmd_data;
            end else begin
               cmd_overflow <= 1'b1;
            end
         end else if (gnt_spi) begin
            pend_v <= 1'b0;
         end
         if (gnt_int) starve <= '0;
         else if (gnt_spi && int_req) starve <= starve + 1'b1;
      end
   end
endmodule

// File: rtl/spi_cfg_ctrl.sv
// spi_cfg_ctrl: 8-bit config-register bank driven by SPI commands and one internal writer.
// Define SPI_CFG_LOCK_EN to make register NUM_REGS-1 bit0 a write lock against SPI writes.
module spi_cfg_ctrl
   import spi_cfg_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int STARVE_MAX = 4
) (
   input logic iclk,
   input logic rstn,
   spi_cfg_if.slave bus
);
   localparam int AW = $clog2(NUM_REGS);
   localparam logic [ADDR_W-1:0] NR = ADDR_W'(NUM_REGS);
   state_t state;
   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [DATA_W-1:0] data_q, gnt_data;
   logic [ADDR_W-1:0] addr_q, gnt_addr;
   logic gnt_v, gnt_int, gnt_rd, lock_blk, ok;
   spi_cfg_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
      .iclk(iclk),
      .rstn(rstn),
      .idle(state == IDLE),
      .cmd_valid(bus.cmd_valid),
      .cmd_addr(bus.cmd_addr),
      .cmd_data(bus.cmd_data),
      .int_req(bus.int_req),
      .int_addr(bus.int_addr),
      .int_data(bus.int_data),
      .gnt_v(gnt_v),
      .gnt_int(gnt_int),
      .gnt_rd(gnt_rd),
      .gnt_addr(gnt_addr),
      .gnt_data(gnt_data),
      .cmd_overflow(bus.cmd_overflow)
   );
`ifdef SPI_CFG_LOCK_EN
   localparam int LK = lock_idx(NUM_REGS);
   assign lock_blk = regs[LK][LOCK_BIT] & !gnt_int & !gnt_rd & (gnt_addr != ADDR_W'(LK));
`else
   assign lock_blk = 1'b0;
`endif
   assign ok = (gnt_addr < NR) & !lock_blk;
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
      assign bus.reg_out[DATA_W*i +: DATA_W] = regs[i];
   end
   always_ff @(posedge iclk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         data_q <= '0;
         addr_q <= '0;
         bus.int_gnt <= 1'b0;
         bus.wr_strobe <= 1'b0;
         bus.wr_addr <= '0;
         bus.rd_data <= '0;
         bus.rd_valid <= 1'b0;
         bus.busy <= 1'b0;
         bus.addr_err <= 1'b0;
      end else begin
         case (state)
            IDLE: if (gnt_v) begin
               state <= gnt_rd ? READ : WRITE;
               bus.busy <= 1'b1;
               addr_q <= gnt_addr;
               data_q <= gnt_data;
               bus.wr_strobe <= !gnt_rd & ok;
               bus.wr_addr <= gnt_addr;
               bus.int_gnt <= gnt_int;
               bus.addr_err <= bus.addr_err | !ok;
            end
            WRITE: begin
               state <= IDLE;
               bus.busy <= 1'b0;
               bus.wr_strobe <= 1'b0;
               bus.int_gnt <= 1'b0;
               if (bus.wr_strobe) regs[addr_q[AW-1:0]] <= data_q;
            end
            READ: begin
               state <= RESP;
               bus.rd_valid <= 1'b1;
               bus.rd_data <= (addr_q < NR) ? regs[addr_q[AW-1:0]] : '0;
            end
            RESP: begin
               state <= IDLE;
               bus.busy <= 1'b0;
               bus.rd_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_spi_cfg_ctrl.sv
// tb_spi_cfg_ctrl: scenario tasks plus randomized transactions checked against a register-array model.
module tb_spi_cfg_ctrl;
   localparam int NR = 16;
   localparam int SM = 4;
   logic iclk = 1'b0;
   logic rstn = 1'b1;
   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] mdl [NR];
   spi_cfg_if #(.NUM_REGS(NR)) bus ();
   spi_cfg_ctrl #(.NUM_REGS(NR), .STARVE_MAX(SM)) dut (.iclk(iclk), .rstn(rstn), .bus(bus));
   always #5 iclk = ~iclk;

   function automatic logic [NR*8-1:0] mdl_vec();
      logic [NR*8-1:0] v;
      for (int i = 0; i < NR; i++) v[8*i +: 8] = mdl[i];
      return v;
   endfunction

   task automatic tick();
      @(posedge iclk);
      #1;
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] d);
      bus.cmd_valid = 1'b1;
      bus.cmd_addr = a;
      bus.cmd_data = d;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      bus.cmd_valid = 0; bus.cmd_addr = 0; bus.cmd_data = 0;
      bus.int_req = 0; bus.int_addr = 0; bus.int_data = 0;
      for (int i = 0; i < NR; i++) mdl[i] = 8'h00;
      #1 rstn = 1'b0;
      #12;
      n_cmp++;
      if ({bus.int_gnt, bus.wr_strobe, bus.rd_valid, bus.busy, bus.cmd_overflow, bus.addr_err, bus.rd_data, bus.wr_addr} !== 21'h0) begin
         n_err++;
         $display("FAIL reset_outputs: got %h expected 0", {bus.int_gnt, bus.wr_strobe, bus.rd_valid, bus.busy, bus.cmd_overflow, bus.addr_err, bus.rd_data, bus.wr_addr});
      end
      n_cmp++;
      if (bus.reg_out !== '0) begin
         n_err++;
         $display("FAIL reset_regs: got %h expected 0", bus.reg_out);
      end
      @(negedge iclk) rstn = 1'b1;
      tick();
   endtask

   task automatic test_write_read();
      send(8'h03, 8'h5A);
      mdl[3] = 8'h5A;
      n_cmp++;
      if (bus.wr_strobe !== 1'b1 || bus.wr_addr !== 7'd3) begin
         n_err++;
         $display("FAIL wr_strobe_n1: got strobe=%b addr=%0d expected 1/3", bus.wr_strobe, bus.wr_addr);
      end
      tick();
      n_cmp++;
      if (bus.reg_out[31:24] !== 8'h5A) begin
         n_err++;
         $display("FAIL reg3_n2: got %h expected 5a", bus.reg_out[31:24]);
      end
      send(8'h83, 8'h00);
      n_cmp++;
      if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b1) begin
         n_err++;
         $display("FAIL read_state: got rd_valid=%b busy=%b expected 0/1", bus.rd_valid, bus.busy);
      end
      tick();
      n_cmp++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h5A) begin
         n_err++;
         $display("FAIL read_resp: got valid=%b data=%h expected 1/5a", bus.rd_valid, bus.rd_data);
      end
      tick();
      n_cmp++;
      if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h5A || bus.busy !== 1'b0 || bus.addr_err !== 1'b0) begin
         n_err++;
         $display("FAIL read_hold: got valid=%b data=%h busy=%b err=%b expected 0/5a/0/0", bus.rd_valid, bus.rd_data, bus.busy, bus.addr_err);
      end
   endtask

   task automatic test_addr_err();
      send(8'hA0, 8'h00);
      tick();
      n_cmp++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h00 || bus.addr_err !== 1'b1) begin
         n_err++;
         $display("FAIL oob_read: got valid=%b data=%h err=%b expected 1/00/1", bus.rd_valid, bus.rd_data, bus.addr_err);
      end
      tick();
      send(8'h20, 8'hEE);
      n_cmp++;
      if (bus.wr_strobe !== 1'b0 || bus.busy !== 1'b1) begin
         n_err++;
         $display("FAIL oob_write: got strobe=%b busy=%b expected 0/1", bus.wr_strobe, bus.busy);
      end
      tick();
      bus.int_req = 1'b1; bus.int_addr = 7'h30; bus.int_data = 8'h99;
      tick();
      bus.int_req = 1'b0;
      n_cmp++;
      if (bus.int_gnt !== 1'b1 || bus.wr_strobe !== 1'b0) begin
         n_err++;
         $display("FAIL oob_int: got gnt=%b strobe=%b expected 1/0", bus.int_gnt, bus.wr_strobe);
      end
      tick();
      n_cmp++;
      if (bus.reg_out !== mdl_vec()) begin
         n_err++;
         $display("FAIL oob_regs: got %h expected %h", bus.reg_out, mdl_vec());
      end
   endtask

   task automatic test_starve();
      logic [7:0] dat [6];
      int spi_before = 0;
      int gnts = 0;
      for (int k = 0; k < 6; k++) dat[k] = 8'($urandom);
      bus.int_req = 1'b1; bus.int_addr = 7'd1; bus.int_data = 8'hC3;
      for (int c = 0; c < 30; c++) begin
         bus.cmd_valid = (c % 2 == 0) && (c < 12);
         bus.cmd_addr = 8'(8 + c / 2);
         bus.cmd_data = dat[(c / 2) % 6];
         tick();
         if (bus.int_gnt === 1'b1) begin
            gnts++;
            bus.int_req = 1'b0;
            n_cmp++;
            if (bus.wr_addr !== 7'd1 || bus.wr_strobe !== 1'b1) begin
               n_err++;
               $display("FAIL starve_gnt_addr: got addr=%0d strobe=%b expected 1/1", bus.wr_addr, bus.wr_strobe);
            end
         end else if (bus.wr_strobe === 1'b1 && gnts == 0) begin
            spi_before++;
         end
      end
      bus.cmd_valid = 1'b0;
      mdl[1] = 8'hC3;
      for (int k = 0; k < 6; k++) mdl[8 + k] = dat[k];
      n_cmp++;
      if (gnts != 1 || spi_before != SM) begin
         n_err++;
         $display("FAIL starve_count: got gnts=%0d spi_before=%0d expected 1/%0d", gnts, spi_before, SM);
      end
      n_cmp++;
      if (bus.reg_out !== mdl_vec() || bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL starve_regs: got %h busy=%b expected %h", bus.reg_out, bus.busy, mdl_vec());
      end
   endtask

   task automatic test_overflow();
      n_cmp++;
      if (bus.cmd_overflow !== 1'b0) begin
         n_err++;
         $display("FAIL ovf_pre: got %b expected 0", bus.cmd_overflow);
      end
      send(8'h83, 8'h00);
      send(8'h04, 8'h11);
      send(8'h05, 8'h22);
      mdl[4] = 8'h11;
      n_cmp++;
      if (bus.cmd_overflow !== 1'b1) begin
         n_err++;
         $display("FAIL ovf_flag: got %b expected 1", bus.cmd_overflow);
      end
      tick();
      n_cmp++;
      if (bus.wr_strobe !== 1'b1 || bus.wr_addr !== 7'd4) begin
         n_err++;
         $display("FAIL ovf_buffered: got strobe=%b addr=%0d expected 1/4", bus.wr_strobe, bus.wr_addr);
      end
      tick();
      tick();
      n_cmp++;
      if (bus.reg_out !== mdl_vec() || bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL ovf_regs: got %h busy=%b expected %h", bus.reg_out, bus.busy, mdl_vec());
      end
   endtask

   task automatic test_random();
      logic [6:0] a;
      logic [7:0] d, exp_rd;
      logic rd, inr;
      for (int t = 0; t < 24; t++) begin
         a = 7'($urandom_range(0, 19));
         rd = 1'($urandom_range(0, 1));
         d = 8'($urandom);
         if (a == 7'(NR - 1)) d[0] = 1'b0;
         inr = a < 7'(NR);
         send({rd, a}, d);
         if (!rd) begin
            n_cmp++;
            if (bus.wr_strobe !== inr || (inr && bus.wr_addr !== a)) begin
               n_err++;
               $display("FAIL rand_wr t%0d: got strobe=%b addr=%0d expected %b/%0d", t, bus.wr_strobe, bus.wr_addr, inr, a);
            end
            if (inr) mdl[a[3:0]] = d;
            tick();
            n_cmp++;
            if (bus.reg_out !== mdl_vec()) begin
               n_err++;
               $display("FAIL rand_regs t%0d: got %h expected %h", t, bus.reg_out, mdl_vec());
            end
         end else begin
            exp_rd = inr ? mdl[a[3:0]] : 8'h00;
            tick();
            n_cmp++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_rd) begin
               n_err++;
               $display("FAIL rand_rd t%0d addr %0d: got valid=%b data=%h expected 1/%h", t, a, bus.rd_valid, bus.rd_data, exp_rd);
            end
            tick();
         end
      end
   endtask

   task automatic test_async_reset();
      send(8'h83, 8'h00);
      #2 rstn = 1'b0;
      #1;
      for (int i = 0; i < NR; i++) mdl[i] = 8'h00;
      n_cmp++;
      if (bus.rd_valid !== 1'b0 || bus.busy !== 1'b0 || bus.reg_out !== '0 || bus.addr_err !== 1'b0 || bus.cmd_overflow !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: got valid=%b busy=%b err=%b ovf=%b regs=%h expected all 0", bus.rd_valid, bus.busy, bus.addr_err, bus.cmd_overflow, bus.reg_out);
      end
      @(negedge iclk) rstn = 1'b1;
      tick();
      send(8'h02, 8'h77);
      mdl[2] = 8'h77;
      n_cmp++;
      if (bus.wr_strobe !== 1'b1 || bus.wr_addr !== 7'd2) begin
         n_err++;
         $display("FAIL post_reset_wr: got strobe=%b addr=%0d expected 1/2", bus.wr_strobe, bus.wr_addr);
      end
      tick();
      n_cmp++;
      if (bus.reg_out !== mdl_vec()) begin
         n_err++;
         $display("FAIL post_reset_regs: got %h expected %h", bus.reg_out, mdl_vec());
      end
   endtask

`ifdef SPI_CFG_LOCK_EN
   task automatic test_lock();
      send(8'(NR - 1), 8'h01);
      tick();
      mdl[NR-1] = 8'h01;
      send(8'h02, 8'hFF);
      n_cmp++;
      if (bus.wr_strobe !== 1'b0 || bus.addr_err !== 1'b1) begin
         n_err++;
         $display("FAIL lock_block: got strobe=%b err=%b expected 0/1", bus.wr_strobe, bus.addr_err);
      end
      tick();
      n_cmp++;
      if (bus.reg_out !== mdl_vec()) begin
         n_err++;
         $display("FAIL lock_regs: got %h expected %h", bus.reg_out, mdl_vec());
      end
      bus.int_req = 1'b1; bus.int_addr = 7'd2; bus.int_data = 8'h3C;
      tick();
      bus.int_req = 1'b0;
      n_cmp++;
      if (bus.int_gnt !== 1'b1 || bus.wr_strobe !== 1'b1) begin
         n_err++;
         $display("FAIL lock_int: got gnt=%b strobe=%b expected 1/1", bus.int_gnt, bus.wr_strobe);
      end
      tick();
      mdl[2] = 8'h3C;
      n_cmp++;
      if (bus.reg_out !== mdl_vec()) begin
         n_err++;
         $display("FAIL lock_int_regs: got %h expected %h", bus.reg_out, mdl_vec());
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write_read();
      test_addr_err();
      test_starve();
      test_overflow();
      test_random();
      test_async_reset();
`ifdef SPI_CFG_LOCK_EN
      test_lock();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
